// File: rtl/aer_to_parallel.sv
// AER receiver: 4-phase REQ/ACK responder that collects spike addresses
// into a per-frame bitmap and, on frame end, streams the bitmap out as
// DATA_WIDTH-bit words over valid/ready before clearing it.
module aer_to_parallel #(
    parameter int DATA_WIDTH = 32,
    parameter int NEUR_NUM   = 256,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  AER_OUT_REQ,
    input  logic [ADDR_WIDTH-1:0] AER_OUT_ADDR,
    output logic                  AER_OUT_ACK,
    input  logic                  frame_end,
    output logic [DATA_WIDTH-1:0] dout_parallel,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CNT_WIDTH-1:0]  spike_cnt,
    output logic                  addr_err,
    output logic                  busy,
    output logic                  finish
);

    localparam int NWORDS = NEUR_NUM / DATA_WIDTH;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BIT_W  = (NEUR_NUM > 1) ? $clog2(NEUR_NUM) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [ADDR_WIDTH:0] NEUR_LIM = (ADDR_WIDTH + 1)'(NEUR_NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK_HI,
        ST_FLUSH,
        ST_CLEAR
    } state_t;

    state_t                r_state;
    logic                  r_req_meta;
    logic                  r_req_s;
    logic                  r_ack;
    logic                  r_pending;
    logic [IDX_W-1:0]      r_idx;
    logic [NEUR_NUM-1:0]   r_bitmap;
    logic [CNT_WIDTH-1:0]  r_spike_cnt;
    logic                  r_addr_err;

    logic                  w_in_range;
    logic [BIT_W-1:0]      w_bit;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_in_range = ({1'b0, AER_OUT_ADDR} < NEUR_LIM);
    assign w_bit      = AER_OUT_ADDR[BIT_W-1:0];

    // Select the bitmap word addressed by the flush index.
    always_comb begin
        w_word = '0;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (r_idx == IDX_W'(w)) begin
                w_word = r_bitmap[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Two-flop synchronizer for the possibly asynchronous request.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
        end else begin
            r_req_meta <= AER_OUT_REQ;
            r_req_s    <= r_req_meta;
        end
    end

    // Handshake / flush FSM together with the bitmap, counter and error flag.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ack       <= 1'b0;
            r_pending   <= 1'b0;
            r_idx       <= '0;
            r_bitmap    <= '0;
            r_spike_cnt <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_req_s) begin
                        if (w_in_range) begin
                            r_bitmap[w_bit] <= 1'b1;
                            if (r_spike_cnt != '1) begin
                                r_spike_cnt <= r_spike_cnt + 1'b1;
                            end
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK_HI;
                        // A frame end colliding with a capture is deferred so
                        // the captured event stays in the current frame.
                        if (frame_end) begin
                            r_pending <= 1'b1;
                        end
                    end else if (frame_end || r_pending) begin
                        r_pending <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= ST_FLUSH;
                    end
                end
                ST_ACK_HI: begin
                    if (frame_end) begin
                        r_pending <= 1'b1;
                    end
                    if (!r_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (frame_end) begin
                        r_pending <= 1'b1;
                    end
                    if (dout_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_CLEAR;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (frame_end) begin
                        r_pending <= 1'b1;
                    end
                    r_bitmap    <= '0;
                    r_spike_cnt <= '0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign AER_OUT_ACK   = r_ack;
    assign dout_valid    = (r_state == ST_FLUSH);
    assign dout_parallel = dout_valid ? w_word : '0;
    assign finish        = (r_state == ST_CLEAR);
    assign busy          = (r_state != ST_IDLE);
    assign spike_cnt     = r_spike_cnt;
    assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_aer_to_parallel.sv
// Self-checking bench for aer_to_parallel: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// frame-level model (set of accepted neurons, event count, error flag).
module tb_aer_to_parallel;

    localparam int DW     = 32;
    localparam int NN     = 256;
    localparam int AW     = 12;
    localparam int CW     = 16;
    localparam int NW     = NN / DW;
    localparam int BUDGET = 400;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          AER_OUT_REQ = 1'b0;
    logic [AW-1:0] AER_OUT_ADDR = '0;
    logic          AER_OUT_ACK;
    logic          frame_end = 1'b0;
    logic [DW-1:0] dout_parallel;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic [CW-1:0] spike_cnt;
    logic          addr_err;
    logic          busy;
    logic          finish;

    always #5 CLK = ~CLK;

    aer_to_parallel #(
        .DATA_WIDTH (DW),
        .NEUR_NUM   (NN),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .AER_OUT_REQ   (AER_OUT_REQ),
        .AER_OUT_ADDR  (AER_OUT_ADDR),
        .AER_OUT_ACK   (AER_OUT_ACK),
        .frame_end     (frame_end),
        .dout_parallel (dout_parallel),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .spike_cnt     (spike_cnt),
        .addr_err      (addr_err),
        .busy          (busy),
        .finish        (finish)
    );

    int            n_checks = 0;
    int            n_err = 0;
    int            n_finish = 0;
    int            n_stall = 0;
    int            xfer = 0;
    int            ready_mode = 0;
    logic [NN-1:0] mbits;
    logic [CW-1:0] mcnt;
    logic          merr;
    logic          prev_ack;
    bit            hold;
    logic [DW-1:0] held;
    logic [DW-1:0] cap [NW];
    time           t_ack = 0;
    time           t_fin = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: actual=timeout required=event at %0t", name, $time);
    endtask

    // Frame-level model and per-cycle comparison, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!rst_n) begin
                mbits    = '0;
                mcnt     = '0;
                merr     = 1'b0;
                prev_ack = 1'b0;
                hold     = 1'b0;
                xfer     = 0;
            end else begin
                if (AER_OUT_ACK && !prev_ack) begin
                    if (int'(AER_OUT_ADDR) < NN) begin
                        mbits[AER_OUT_ADDR] = 1'b1;
                        if (mcnt != '1) mcnt = mcnt + 1'b1;
                    end else begin
                        merr = 1'b1;
                    end
                end
                prev_ack = AER_OUT_ACK;
                chk("spike_cnt", 32'(spike_cnt), 32'(mcnt));
                chk("addr_err", 32'(addr_err), 32'(merr));
                chk("busy", 32'(busy), 32'(AER_OUT_ACK | dout_valid | finish));
                if (dout_valid) begin
                    if (xfer >= NW) begin
                        chk("extra_word_index", xfer, NW - 1);
                    end else begin
                        chk($sformatf("word%0d", xfer), dout_parallel, mbits[xfer*DW +: DW]);
                    end
                    if (hold) chk("hold_stable", dout_parallel, held);
                    if (dout_ready) begin
                        if (xfer < NW) cap[xfer] = dout_parallel;
                        xfer++;
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        held = dout_parallel;
                        n_stall++;
                    end
                end else begin
                    if (hold) chk("valid_dropped_while_stalled", 32'(dout_valid), 1);
                    hold = 1'b0;
                end
                if (finish) begin
                    chk("transfers_per_flush", xfer, NW);
                    n_finish++;
                    xfer  = 0;
                    mbits = '0;
                    mcnt  = '0;
                end
            end
        end
    end

    // Downstream ready: always, 1-0-0 pattern, or random.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = (cyc % 3 == 0);
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_event(input logic [AW-1:0] a, input bit lat, input bit fe_in_ack);
        int n;
        @(posedge CLK);
        #1;
        AER_OUT_ADDR = a;
        AER_OUT_REQ  = 1'b1;
        n = 0;
        while (!AER_OUT_ACK && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!AER_OUT_ACK) fail("ack_rise");
        else begin
            t_ack = $time;
            if (lat) chk("ack_rise_latency", n, 3);
        end
        if (fe_in_ack) begin
            frame_end = 1'b1;
            @(posedge CLK);
            #1;
            frame_end = 1'b0;
        end
        AER_OUT_REQ = 1'b0;
        n = 0;
        while (AER_OUT_ACK && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (AER_OUT_ACK) fail("ack_fall");
        else if (lat) chk("ack_fall_latency", n, 3);
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        @(posedge CLK);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic wait_finish();
        int start;
        int n;
        start = n_finish;
        n = 0;
        while (n_finish == start && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n_finish == start) fail("finish_wait");
    endtask

    task automatic clear_cap();
        foreach (cap[i]) cap[i] = '1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(AER_OUT_ACK), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_dout"}, dout_parallel, 0);
        chk({tag, "_cnt"}, 32'(spike_cnt), 0);
        chk({tag, "_err"}, 32'(addr_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_finish"}, 32'(finish), 0);
    endtask

    initial begin
        int            f0;
        int            s0;
        logic [AW-1:0] a;

        rst_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // Single event at 5, then a flush with ready held high.
        send_event(12'd5, 1'b1, 1'b0);
        chk("t1_cnt", 32'(spike_cnt), 1);
        clear_cap();
        f0 = n_finish;
        pulse_frame_end();
        chk("t1_valid_after_frame_end", 32'(dout_valid), 1);
        wait_finish();
        chk("t1_word0", cap[0], 32'h0000_0020);
        for (int i = 1; i < NW; i++) chk($sformatf("t1_word%0d", i), cap[i], 0);
        cycles(3);
        chk("t1_finish_once", n_finish - f0, 1);
        chk("t1_cnt_cleared", 32'(spike_cnt), 0);

        // Boundary addresses including a duplicate.
        send_event(12'd0, 1'b0, 1'b0);
        send_event(12'd31, 1'b0, 1'b0);
        send_event(12'd32, 1'b0, 1'b0);
        send_event(12'd255, 1'b0, 1'b0);
        send_event(12'd32, 1'b0, 1'b0);
        chk("t2_cnt", 32'(spike_cnt), 5);
        clear_cap();
        pulse_frame_end();
        wait_finish();
        chk("t2_word0", cap[0], 32'h8000_0001);
        chk("t2_word1", cap[1], 32'h0000_0001);
        chk("t2_word7", cap[7], 32'h8000_0000);
        for (int i = 2; i < 7; i++) chk($sformatf("t2_word%0d", i), cap[i], 0);

        // Backpressure with a 1,0,0 ready pattern.
        send_event(12'd1, 1'b0, 1'b0);
        send_event(12'd100, 1'b0, 1'b0);
        send_event(12'd200, 1'b0, 1'b0);
        clear_cap();
        s0 = n_stall;
        ready_mode = 1;
        pulse_frame_end();
        wait_finish();
        ready_mode = 0;
        chk("t3_word0", cap[0], 32'h0000_0002);
        chk("t3_word3", cap[3], 32'h0000_0010);
        chk("t3_word6", cap[6], 32'h0000_0100);
        chk("t3_stalls_seen", 32'(n_stall > s0), 1);

        // Out-of-range address.
        send_event(12'd300, 1'b0, 1'b0);
        chk("t4_err", 32'(addr_err), 1);
        chk("t4_cnt", 32'(spike_cnt), 0);
        clear_cap();
        pulse_frame_end();
        wait_finish();
        for (int i = 0; i < NW; i++) chk($sformatf("t4_word%0d", i), cap[i], 0);
        chk("t4_err_sticky", 32'(addr_err), 1);

        // frame_end during ACK_HI, then REQ raised during the flush.
        send_event(12'd7, 1'b0, 1'b1);
        cycles(1);
        chk("t5_flush_after_ack_fall", 32'(dout_valid), 1);
        clear_cap();
        fork
            begin
                wait_finish();
                t_fin = $time;
            end
            send_event(12'd40, 1'b0, 1'b0);
        join
        chk("t5_word0", cap[0], 32'h0000_0080);
        chk("t5_word1", cap[1], 0);
        chk("t5_req_held_off", 32'(t_ack > t_fin), 1);
        clear_cap();
        pulse_frame_end();
        wait_finish();
        chk("t5_next_word0", cap[0], 0);
        chk("t5_next_word1", cap[1], 32'h0000_0100);

        // Reset for one cycle in the middle of a flush.
        send_event(12'd9, 1'b0, 1'b0);
        pulse_frame_end();
        chk("t6_flushing", 32'(dout_valid), 1);
        cycles(3);
        rst_n = 1'b0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("t6_reset");
        f0 = n_finish;
        cycles(12);
        chk("t6_no_finish", n_finish - f0, 0);
        clear_cap();
        pulse_frame_end();
        wait_finish();
        for (int i = 0; i < NW; i++) chk($sformatf("t6_word%0d", i), cap[i], 0);

        // Randomized events, frame ends and ready against the model.
        f0 = n_finish;
        ready_mode = 2;
        fork
            begin
                repeat (60) begin
                    repeat ($urandom_range(0, 6)) @(posedge CLK);
                    if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(256, 4095));
                    else a = AW'($urandom_range(0, 255));
                    send_event(a, 1'b0, 1'b0);
                end
            end
            begin
                repeat (12) begin
                    repeat ($urandom_range(10, 60)) @(posedge CLK);
                    #1;
                    frame_end = 1'b1;
                    @(posedge CLK);
                    #1;
                    frame_end = 1'b0;
                end
            end
        join
        s0 = 0;
        while (busy && s0 < BUDGET) begin
            cycles(1);
            s0++;
        end
        if (busy) fail("random_idle");
        cycles(4);
        ready_mode = 0;
        pulse_frame_end();
        wait_finish();
        chk("random_flushes_seen", 32'(n_finish - f0 > 1), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
